fifo_block_packer: RTL and testbench
====================================

FIFO_BLOCK_PACKER -- requirements
Module: fifo_block_packer

Interface
REQ-001 SHALL have parameter DW, default 8, FIFO word width in bits.
REQ-002 SHALL have parameter NB, default 16, words per block; legal NB >= 2; CW = $clog2(NB)+1.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port arst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port fifo_dout  input  DW  read data of upstream fifo, valid whenever fifo_empty=0.
REQ-006 SHALL have port fifo_empty  input  1  upstream fifo empty flag.
REQ-007 SHALL have port fifo_pop  output  1  pop strobe to upstream fifo; fifo_dout is consumed on the same edge.
REQ-008 SHALL have port flush  input  1  single-cycle request to close the partially filled block.
REQ-009 SHALL have port blk_data  output  DW*NB  packed block; word i at bits [i*DW +: DW].
REQ-010 SHALL have port blk_valid  output  1  block available.
REQ-011 SHALL have port blk_ready  input  1  downstream accepts block.
REQ-012 SHALL have port blk_cnt  output  CW  number of real data words in block (1..NB).
REQ-013 SHALL have port blk_partial  output  1  block closed by flush before reaching NB words.
REQ-014 SHALL have port busy  output  1  high in PAD and OUT states.

Function
REQ-015 SHALL implement FSM states FILL, PAD, OUT plus word counter wcnt (0..NB-1).
REQ-016 FILL: fifo_pop = ~fifo_empty, combinational; on pop, fifo_dout written to word wcnt, wcnt increments.
REQ-017 FILL: pop with wcnt=NB-1 -> OUT next cycle, blk_cnt=NB, blk_partial=0, wcnt=0.
REQ-018 FILL: flush -> close after including any word popped that cycle; if resulting word count k in 1..NB-1 -> PAD, blk_cnt=k, blk_partial=1.
REQ-019 FILL: flush coinciding with the NB-th pop -> handled per REQ-017 only; no extra block.
REQ-020 FILL: flush with zero words captured and no pop -> ignored, no block emitted.
REQ-021 PAD: fifo_pop=0; one pad word written per cycle at index wcnt, wcnt increments; after writing index NB-1 -> OUT; PAD lasts NB-k cycles.
REQ-022 OUT: blk_valid=1, fifo_pop=0, blk_data/blk_cnt/blk_partial stable; on blk_valid & blk_ready -> FILL, blk_valid low next cycle.
REQ-023 flush in PAD or OUT SHALL be ignored.
REQ-024 Minimum cadence SHALL be NB pop cycles + 1 OUT cycle per full block with blk_ready=1.
REQ-025 fifo_pop SHALL never assert while fifo_empty=1 or arst_n=0.

Reset
REQ-026 arst_n low SHALL immediately force state FILL, wcnt=0, blk_data=0, blk_valid=0, blk_cnt=0, blk_partial=0, busy=0, fifo_pop=0.
REQ-027 Reset mid-operation SHALL discard the partial or pending block; already-popped words are lost; next block starts at word 0.

Configuration
REQ-028 Macro FIFO_BLOCK_PACKER_PAD_EN SHALL select pad content.
REQ-029 Defined: first pad word = MSB set, others zero (DW=8: 0x80), remaining pad words = 0 (ISO/IEC 7816-4 style).
REQ-030 Undefined: all pad words = 0; FSM timing identical in both builds.

Verification (DW=8, NB=16)
REQ-031 Bytes 0x00..0x0F in fifo, blk_ready=1 -> 16 consecutive pops, blk_valid one cycle after last pop, blk_data[7:0]=0x00, [127:120]=0x0F, blk_cnt=16, blk_partial=0.
REQ-032 Bytes 0xA1..0xA5 then flush -> 11 PAD cycles, bytes0-4=A1..A5, byte5=0x80 (PAD_EN) or 0x00, bytes6-15=0x00, blk_cnt=5, blk_partial=1.
REQ-033 20 bytes queued, blk_ready=0 for 10 cycles in OUT -> fifo_pop=0, blk_data stable; after ready, remaining 4 bytes popped into next block at words 0-3.
REQ-034 flush with empty fifo and wcnt=0 -> no blk_valid, busy stays 0.
REQ-035 flush on same cycle as 16th pop -> exactly one block, blk_cnt=16, blk_partial=0.
REQ-036 arst_n low at wcnt=7 -> fifo_pop, blk_valid drop without clock edge; after release next block word 0 = first byte then in fifo.

Source files
------------

// File: rtl/fifo_block_packer.sv
// Pops words from an upstream FIFO and packs them into NB-word blocks; flush closes a partial block.
// Define FIFO_BLOCK_PACKER_PAD_EN to mark the first pad word with its MSB set (0x80-style padding).
module fifo_block_packer #(
  parameter int DW = 8,
  parameter int NB = 16,
  localparam int CW = $clog2(NB) + 1
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic [DW-1:0]   fifo_dout,
  input  logic            fifo_empty,
  output logic            fifo_pop,
  input  logic            flush,
  output logic [DW*NB-1:0] blk_data,
  output logic            blk_valid,
  input  logic            blk_ready,
  output logic [CW-1:0]   blk_cnt,
  output logic            blk_partial,
  output logic            busy
);

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] PAD  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(NB - 1);
  localparam logic [CW-1:0] FULL = CW'(NB);

  logic [1:0]    state;
  logic [CW-1:0] wcnt;
  logic [CW-1:0] wcnt_inc;
  logic [DW-1:0] pad_word;
  logic [DW-1:0] wr_word;
  logic          wr_en;

  assign wcnt_inc = wcnt + CW'(1);

  // The pop strobe is gated by reset so it drops the instant arst_n falls.
  assign fifo_pop  = arst_n & (state == FILL) & ~fifo_empty;
  assign blk_valid = (state == OUT);
  assign busy      = (state != FILL);

`ifdef FIFO_BLOCK_PACKER_PAD_EN
  // blk_cnt holds k during PAD, so index k is the first pad slot.
  assign pad_word = (wcnt == blk_cnt) ? {1'b1, {(DW-1){1'b0}}} : '0;
`else
  assign pad_word = '0;
`endif

  assign wr_en   = fifo_pop | (state == PAD);
  assign wr_word = (state == PAD) ? pad_word : fifo_dout;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= FILL;
      wcnt        <= '0;
      blk_data    <= '0;
      blk_cnt     <= '0;
      blk_partial <= 1'b0;
    end else begin
      if (wr_en) begin
        for (int i = 0; i < NB; i++) begin
          if (wcnt == CW'(i)) blk_data[i*DW +: DW] <= wr_word;
        end
      end
      case (state)
        FILL: begin
          if (fifo_pop && (wcnt == LAST)) begin
            state       <= OUT;
            wcnt        <= '0;
            blk_cnt     <= FULL;
            blk_partial <= 1'b0;
          end else if (flush && (fifo_pop || (wcnt != '0))) begin
            // Any word popped alongside the flush belongs to the closing block.
            state       <= PAD;
            wcnt        <= fifo_pop ? wcnt_inc : wcnt;
            blk_cnt     <= fifo_pop ? wcnt_inc : wcnt;
            blk_partial <= 1'b1;
          end else if (fifo_pop) begin
            wcnt <= wcnt_inc;
          end
        end
        PAD: begin
          if (wcnt == LAST) begin
            state <= OUT;
            wcnt  <= '0;
          end else begin
            wcnt <= wcnt_inc;
          end
        end
        OUT: begin
          if (blk_ready) state <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_block_packer.sv
// Randomized scoreboard bench for fifo_block_packer against a queue-based block model.
module tb_fifo_block_packer;
  localparam int DW = 8;
  localparam int NB = 16;
  localparam int CW = $clog2(NB) + 1;

  logic            clk = 1'b0;
  logic            arst_n;
  logic [DW-1:0]   fifo_dout;
  logic            fifo_empty;
  logic            fifo_pop;
  logic            flush;
  logic [DW*NB-1:0] blk_data;
  logic            blk_valid;
  logic            blk_ready;
  logic [CW-1:0]   blk_cnt;
  logic            blk_partial;
  logic            busy;

  fifo_block_packer #(.DW(DW), .NB(NB)) dut (
    .clk(clk), .arst_n(arst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_pop(fifo_pop), .flush(flush), .blk_data(blk_data), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .blk_cnt(blk_cnt), .blk_partial(blk_partial), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW*NB-1:0] data;
    int               cnt;
    bit               partial;
  } blk_t;

  blk_t          sb[$];
  logic [DW-1:0] q[$];
  logic [DW-1:0] cur[$];
  int            pad_left;
  bit            out_pending;
  logic [DW-1:0] pad_first;
  int            vectors;
  int            miscompares;

  task automatic chk(input string name, input logic [DW*NB-1:0] act, input logic [DW*NB-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (q.size() == 0);
    fifo_dout  = fifo_empty ? '0 : q[0];
  endtask

  task automatic push(input logic [DW-1:0] v);
    q.push_back(v);
    drive_fifo();
  endtask

  function automatic blk_t make_blk(input bit partial);
    blk_t b;
    b.data    = '0;
    b.cnt     = cur.size();
    b.partial = partial;
    for (int i = 0; i < cur.size(); i++) b.data[i*DW +: DW] = cur[i];
    if (cur.size() < NB) b.data[cur.size()*DW +: DW] = pad_first;
    return b;
  endfunction

  function automatic bit idle();
    return !out_pending && (pad_left == 0);
  endfunction

  // One clock cycle: entered and left at posedge+1.
  task automatic step(input bit fl, input bit rdy);
    bit exp_busy, exp_pop;
    flush     = fl;
    blk_ready = rdy;
    #2;
    exp_busy = !idle();
    exp_pop  = !exp_busy && (q.size() > 0);
    chk("fifo_pop", fifo_pop, exp_pop);
    chk("busy", busy, exp_busy);
    chk("blk_valid", blk_valid, out_pending);
    if (out_pending) begin
      if (rdy) out_pending = 0;
    end else if (pad_left > 0) begin
      pad_left--;
      if (pad_left == 0) out_pending = 1;
    end else begin
      if (exp_pop) cur.push_back(q[0]);
      if (cur.size() == NB) begin
        sb.push_back(make_blk(1'b0));
        cur.delete();
        out_pending = 1;
      end else if (fl && cur.size() > 0) begin
        sb.push_back(make_blk(1'b1));
        pad_left = NB - cur.size();
        cur.delete();
      end
    end
    @(posedge clk);
    if (exp_pop) void'(q.pop_front());
    #1;
    drive_fifo();
    flush = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_fifo_pop"}, fifo_pop, 0);
    chk({tag, "_blk_valid"}, blk_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_blk_cnt"}, blk_cnt, 0);
    chk({tag, "_blk_partial"}, blk_partial, 0);
    chk({tag, "_blk_data"}, blk_data, 0);
  endtask

  // Reset asserted mid-cycle with no clock edge in between; outputs must drop at once.
  task automatic async_reset(input string tag);
    #2;
    arst_n = 1'b0;
    #1;
    reset_checks(tag);
    cur.delete();
    sb.delete();
    pad_left    = 0;
    out_pending = 0;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (arst_n && blk_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL blk_unexpected at %0t: got block cnt %0d expected none", $time, blk_cnt);
      end else begin
        chk("blk_data", blk_data, sb[0].data);
        if (blk_ready) begin
          chk("blk_cnt", blk_cnt, sb[0].cnt);
          chk("blk_partial", blk_partial, sb[0].partial);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    bit fl, rdy;
    vectors     = 0;
    miscompares = 0;
    pad_left    = 0;
    out_pending = 0;
`ifdef FIFO_BLOCK_PACKER_PAD_EN
    pad_first = 8'h80;
`else
    pad_first = 8'h00;
`endif
    arst_n    = 1'b0;
    flush     = 1'b0;
    blk_ready = 1'b1;
    push(8'h5A);
    #3;
    reset_checks("por");
    q.delete();
    drive_fifo();
    @(posedge clk);
    #1;
    arst_n = 1'b1;

    for (int i = 0; i < 16; i++) push(i[DW-1:0]);
    repeat (20) step(1'b0, 1'b1);

    for (int i = 1; i <= 5; i++) push(8'hA0 + i[DW-1:0]);
    repeat (6) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (16) step(1'b0, 1'b1);

    for (int i = 0; i < 20; i++) push(8'hB0 + i[DW-1:0]);
    repeat (26) step(1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (18) step(1'b0, 1'b1);

    repeat (5) step(1'b1, 1'b1);

    for (int i = 0; i < 16; i++) push(8'hC0 + i[DW-1:0]);
    repeat (20) begin
      fl = idle() && (cur.size() == NB - 1) && (q.size() > 0);
      step(fl, 1'b1);
    end

    for (int i = 0; i < 10; i++) push(8'hD0 + i[DW-1:0]);
    repeat (7) step(1'b0, 1'b1);
    async_reset("rst_fill");
    repeat (4) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (16) step(1'b0, 1'b1);

    for (int i = 0; i < 16; i++) push(8'hE0 + i[DW-1:0]);
    repeat (18) step(1'b0, 1'b0);
    async_reset("rst_out");
    repeat (3) step(1'b0, 1'b1);

    repeat (3000) begin
      if ($urandom_range(0, 99) < 40) push(DW'($urandom));
      fl  = ($urandom_range(0, 99) < 4);
      rdy = ($urandom_range(0, 99) < 70);
      step(fl, rdy);
    end

    repeat (400) begin
      fl = idle() && (q.size() == 0) && (cur.size() > 0);
      step(fl, 1'b1);
    end
    chk("drain_fifo_left", q.size(), 0);
    chk("drain_blocks_left", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
